wbp_memslave: RTL

//  Pipelined wishbone responder: on-chip RAM slave that accepts one request
//  per clock (cyc/stb/!stall) and returns in-order acks after a fixed latency.

---
 rtl/wbp_pkg.sv | 29 ++
 rtl/wbp_delay_line.sv | 46 ++++
 rtl/wbp_memslave.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/wbp_pkg.sv
// ---------------------------------------------------------------------------
// wbp_pkg
//   Shared types for the pipelined wishbone memory slave:
//     state_t     : responder FSM encoding (IDLE / ACTIVE / ERRWAIT)
//     MAX_LATENCY : deepest request-to-response pipeline supported
//     token_t     : one in-flight request as it travels to the response side
// ---------------------------------------------------------------------------
package wbp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    ERRWAIT = 2'd2
  } state_t;

  localparam int MAX_LATENCY = 4;

  // valid : slot holds a live request
  // we    : request was a write (its ack carries no read data)
  // err   : request had an out-of-range address and must answer with err
  // data  : read data captured on the accept edge
  typedef struct packed {
    logic        valid;
    logic        we;
    logic        err;
    logic [31:0] data;
  } token_t;

endpackage

// File: rtl/wbp_delay_line.sv
// ---------------------------------------------------------------------------
// wbp_delay_line
//   Fixed-depth shift register of request tokens. A token pushed in on one
//   edge appears on tok_old LATENCY edges later. flush (and rst) empty every
//   slot, including the token presented on the same edge.
//
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   flush    in   synchronous clear of all slots
//   tok_new  in   token entering the line this edge
//   tok_old  out  oldest token, leaving the line this cycle
// ---------------------------------------------------------------------------
module wbp_delay_line
  import wbp_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   flush,
  input  token_t tok_new,
  output token_t tok_old
);

  // Out-of-range settings are pulled back to the nearest supported depth.
  localparam int DEPTH = (LATENCY < 1) ? 1 :
                         ((LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY);

  token_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tok_new;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tok_old = stage[DEPTH-1];

endmodule

// File: rtl/wbp_memslave.sv
// ---------------------------------------------------------------------------
// wbp_memslave
//   Pipelined wishbone block-RAM responder. Accepts one request per clock,
//   answers each with ack (or err for an out-of-range address) exactly
//   LATENCY cycles after it was accepted, strictly in order. A programmable
//   stall is inserted after every STALL_GAP accepts so masters see back
//   pressure; an err aborts the rest of the burst until cyc drops.
//
//   i_clk       in   system clock
//   i_rst       in   synchronous active-high reset
//   i_wb_cyc    in   bus cycle active
//   i_wb_stb    in   request strobe
//   i_wb_we     in   1 = write, 0 = read
//   i_wb_addr   in   word address (AW bits)
//   i_wb_data   in   write data
//   o_wb_ack    out  one pulse per successful request
//   o_wb_stall  out  request not accepted this cycle
//   o_wb_err    out  one-cycle pulse when a bad-address request completes
//   o_wb_data   out  read data, valid with a read ack, held otherwise
// ---------------------------------------------------------------------------
module wbp_memslave
  import wbp_pkg::*;
#(
  parameter int AW        = 32,
  parameter int LGMEMSZ   = 10,
  parameter int LATENCY   = 2,
  parameter int STALL_GAP = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [31:0]   i_wb_data,
  output logic          o_wb_ack,
  output logic          o_wb_stall,
  output logic          o_wb_err,
  output logic [31:0]   o_wb_data
);

  localparam int            CW      = (STALL_GAP < 1) ? 1 : $clog2(STALL_GAP + 1);
  localparam logic [CW-1:0] GAP_VAL = CW'(STALL_GAP);

  logic [31:0]        mem [2**LGMEMSZ];
  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      gap_cnt;
  logic [31:0]        data_hold;
  token_t             tok_new;
  token_t             tok_old;
  logic [LGMEMSZ-1:0] word_idx;
  logic               addr_ok;
  logic               accept;
  logic               gap_hit;
  logic               err_exit;
  logic               flush;
  logic               read_ack;

  assign word_idx = i_wb_addr[LGMEMSZ-1:0];
  assign addr_ok  = (i_wb_addr[AW-1:LGMEMSZ] == '0);
  assign accept   = i_wb_cyc & i_wb_stb & ~o_wb_stall;

  // The owed stall cycle is pending once the accept count reaches the gap.
  assign gap_hit  = (STALL_GAP != 0) && (gap_cnt == GAP_VAL);

  // Tokens only exist while ACTIVE; the state term keeps that explicit.
  assign err_exit = tok_old.valid & tok_old.err & (state == ACTIVE);

  // Bad-address and write requests carry no read data down the pipe.
  always_comb begin
    tok_new       = '0;
    tok_new.valid = accept;
    tok_new.we    = i_wb_we;
    tok_new.err   = ~addr_ok;
    if (!i_wb_we && addr_ok) begin
      tok_new.data = mem[word_idx];
    end
  end

  // Next state and bus handshake. The err cycle also stalls so no request
  // (in particular no write) is taken while the burst is being aborted.
  always_comb begin
    state_next = state;
    o_wb_stall = 1'b0;
    o_wb_ack   = 1'b0;
    o_wb_err   = 1'b0;
    flush      = 1'b0;
    case (state)
      IDLE: begin
        flush      = ~i_wb_cyc;
        o_wb_stall = i_wb_cyc & gap_hit;
        if (i_wb_cyc) begin
          state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        if (!i_wb_cyc) begin
          flush      = 1'b1;
          state_next = IDLE;
        end else if (err_exit) begin
          o_wb_err   = 1'b1;
          o_wb_stall = 1'b1;
          flush      = 1'b1;
          state_next = ERRWAIT;
        end else begin
          o_wb_stall = gap_hit;
          o_wb_ack   = tok_old.valid;
        end
      end
      ERRWAIT: begin
        o_wb_stall = 1'b1;
        flush      = 1'b1;
        if (!i_wb_cyc) begin
          state_next = IDLE;
        end
      end
      default: begin
        flush      = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  assign read_ack  = o_wb_ack & ~tok_old.we;
  assign o_wb_data = read_ack ? tok_old.data : data_hold;

  // Memory contents survive reset; only the write port is gated by it.
  always_ff @(posedge i_clk) begin
    if (accept && i_wb_we && addr_ok && !i_rst) begin
      mem[word_idx] <= i_wb_data;
    end
  end

  // State register, stall counter and read-data holding register. The
  // counter only moves while cyc is high, so it holds across idle periods.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      data_hold <= '0;
    end else begin
      state <= state_next;
      if (i_wb_cyc && gap_hit) begin
        gap_cnt <= '0;
      end else if (accept && (STALL_GAP != 0)) begin
        gap_cnt <= gap_cnt + CW'(1);
      end
      if (read_ack) begin
        data_hold <= tok_old.data;
      end
    end
  end

  wbp_delay_line #(
    .LATENCY(LATENCY)
  ) u_delay (
    .clk     (i_clk),
    .rst     (i_rst),
    .flush   (flush),
    .tok_new (tok_new),
    .tok_old (tok_old)
  );

endmodule
